title_seq_ctrl: RTL

Screen-flow sequencer driving the 4-bit `status` bus consumed by the title renderer and the other screen/sprite blocks.
- Runs boot delay, title fade-in, blinking "press ENTER" prompt, fade-out into gameplay, and the game-over-to-title return.
- Timing is counted in video frames, derived from the VGA frame_clk.
- Keyboard input is taken from the USB keycode bus.

---
 rtl/screen_pkg.sv | 45 ++++
 rtl/frame_tick_gen.sv | 32 +++
 rtl/title_seq_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - shared screen-flow status codes, state type and key defaults
//
// Contents:
//   STATUS_* : 4-bit status bus values consumed by the title renderer and other screen blocks
//   screen_state_t : screen sequencer states
//   ENTER_CODE_DEFAULT : keycode that advances the screen
//   ALPHA_MAX : full title brightness
//   state_status() : maps a sequencer state onto the status bus value

package screen_pkg;

  localparam logic [3:0] STATUS_BOOT     = 4'd0;
  localparam logic [3:0] STATUS_TITLE    = 4'd1;
  localparam logic [3:0] STATUS_GAME     = 4'd2;
  localparam logic [3:0] STATUS_GAMEOVER = 4'd3;

  localparam logic [7:0] ENTER_CODE_DEFAULT = 8'h28;
  localparam logic [2:0] ALPHA_MAX          = 3'd7;

  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_FADE_IN  = 3'd1,
    ST_IDLE     = 3'd2,
    ST_FADE_OUT = 3'd3,
    ST_GAME     = 3'd4,
    ST_GAMEOVER = 3'd5
  } screen_state_t;

  // Fades and the idle prompt all present as TITLE to downstream blocks.
  function automatic logic [3:0] state_status(input screen_state_t s);
    logic [3:0] r;
    r = STATUS_BOOT;
    case (s)
      ST_BOOT:     r = STATUS_BOOT;
      ST_FADE_IN,
      ST_IDLE,
      ST_FADE_OUT: r = STATUS_TITLE;
      ST_GAME:     r = STATUS_GAME;
      ST_GAMEOVER: r = STATUS_GAMEOVER;
      default:     r = STATUS_BOOT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - registers frame_clk and emits a one-cycle pulse per frame
//
// Ports:
//   Clk       in  system clock
//   Reset     in  asynchronous active-high reset
//   frame_clk in  frame clock, synchronous to Clk
//   tick      out one Clk cycle high per rising edge of the registered frame_clk

module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic frame_q;
  logic frame_prev;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_q    <= 1'b0;
      frame_prev <= 1'b0;
    end else begin
      frame_q    <= frame_clk;
      frame_prev <= frame_q;
    end
  end

  // Both inputs are flops, so the pulse is glitch-free and exactly one cycle wide.
  assign tick = frame_q & ~frame_prev;

endmodule

// File: rtl/title_seq_ctrl.sv
// rtl/title_seq_ctrl.sv - screen-flow sequencer: boot, title fades, prompt blink, game, game over
//
// Ports:
//   Clk           in  system clock
//   Reset         in  asynchronous active-high reset
//   frame_clk     in  frame clock, synchronous to Clk
//   keycode       in  current key, 8'h00 when none
//   game_over     in  one-cycle pulse from game logic
//   status        out 0=BOOT 1=TITLE 2=GAME 3=GAMEOVER
//   title_alpha   out title brightness 0..7
//   prompt_on     out "press ENTER" text visible
//   in_transition out high during either fade

module title_seq_ctrl
  import screen_pkg::*;
#(
  parameter int unsigned BOOT_FRAMES = 30,
  parameter int unsigned FADE_STEP   = 4,
  parameter int unsigned BLINK_HALF  = 30,
  parameter logic [7:0]  ENTER_CODE  = ENTER_CODE_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       game_over,
  output logic [3:0] status,
  output logic [2:0] title_alpha,
  output logic       prompt_on,
  output logic       in_transition
);

  localparam logic [7:0] BOOT_LAST  = 8'(BOOT_FRAMES - 1);
  localparam logic [7:0] FADE_LAST  = 8'(FADE_STEP - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_HALF - 1);

  logic tick;

  frame_tick_gen u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  screen_state_t state, state_d;
  logic [7:0]    frame_cnt, frame_cnt_d;
  logic [7:0]    blink_cnt, blink_cnt_d;
  logic [2:0]    alpha, alpha_d;
  logic          prompt_q, prompt_d;
  logic [3:0]    status_q, status_d;
  logic          in_tr_q, in_tr_d;
  logic          key_armed;

  logic enter;
  logic press;

  assign enter = (keycode == ENTER_CODE);
  // key_armed is only ever set by a non-ENTER cycle, so a held key yields a single press.
  assign press = enter & key_armed;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_BOOT;
      frame_cnt <= 8'd0;
      blink_cnt <= 8'd0;
      alpha     <= 3'd0;
      prompt_q  <= 1'b0;
      status_q  <= STATUS_BOOT;
      in_tr_q   <= 1'b0;
      key_armed <= 1'b0;
    end else begin
      state     <= state_d;
      frame_cnt <= frame_cnt_d;
      blink_cnt <= blink_cnt_d;
      alpha     <= alpha_d;
      prompt_q  <= prompt_d;
      status_q  <= status_d;
      in_tr_q   <= in_tr_d;
      key_armed <= ~enter;
    end
  end

  always_comb begin
    state_d     = state;
    frame_cnt_d = frame_cnt;
    blink_cnt_d = blink_cnt;
    alpha_d     = alpha;
    prompt_d    = prompt_q;

    case (state)
      ST_BOOT: begin
        alpha_d  = 3'd0;
        prompt_d = 1'b0;
        if (tick) begin
          if (frame_cnt == BOOT_LAST) begin
            state_d     = ST_FADE_IN;
            frame_cnt_d = 8'd0;
          end else begin
            frame_cnt_d = frame_cnt + 8'd1;
          end
        end
      end

      ST_FADE_IN: begin
        prompt_d = 1'b0;
        // A press skips the rest of the fade; it takes priority over a same-cycle tick.
        if (press) begin
          state_d     = ST_IDLE;
          alpha_d     = ALPHA_MAX;
          frame_cnt_d = 8'd0;
          blink_cnt_d = 8'd0;
          prompt_d    = 1'b1;
        end else if (tick) begin
          if (frame_cnt == FADE_LAST) begin
            frame_cnt_d = 8'd0;
            if (alpha >= ALPHA_MAX - 3'd1) begin
              state_d     = ST_IDLE;
              alpha_d     = ALPHA_MAX;
              blink_cnt_d = 8'd0;
              prompt_d    = 1'b1;
            end else begin
              alpha_d = alpha + 3'd1;
            end
          end else begin
            frame_cnt_d = frame_cnt + 8'd1;
          end
        end
      end

      ST_IDLE: begin
        alpha_d = ALPHA_MAX;
        if (press) begin
          state_d     = ST_FADE_OUT;
          frame_cnt_d = 8'd0;
          blink_cnt_d = 8'd0;
          prompt_d    = 1'b0;
        end else if (tick) begin
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt_d = 8'd0;
            prompt_d    = ~prompt_q;
          end else begin
            blink_cnt_d = blink_cnt + 8'd1;
          end
        end
      end

      ST_FADE_OUT: begin
        prompt_d = 1'b0;
        if (tick) begin
          if (frame_cnt == FADE_LAST) begin
            frame_cnt_d = 8'd0;
            if (alpha <= 3'd1) begin
              state_d = ST_GAME;
              alpha_d = 3'd0;
            end else begin
              alpha_d = alpha - 3'd1;
            end
          end else begin
            frame_cnt_d = frame_cnt + 8'd1;
          end
        end
      end

      ST_GAME: begin
        alpha_d     = 3'd0;
        prompt_d    = 1'b0;
        frame_cnt_d = 8'd0;
        if (game_over) begin
          state_d = ST_GAMEOVER;
        end
      end

      ST_GAMEOVER: begin
        alpha_d     = 3'd0;
        prompt_d    = 1'b0;
        frame_cnt_d = 8'd0;
        if (press) begin
          state_d = ST_FADE_IN;
        end
      end

      default: begin
        state_d     = ST_BOOT;
        frame_cnt_d = 8'd0;
        blink_cnt_d = 8'd0;
        alpha_d     = 3'd0;
        prompt_d    = 1'b0;
      end
    endcase

    // Outputs are registered from the next state so they move in the same cycle as the state.
    status_d = state_status(state_d);
    in_tr_d  = (state_d == ST_FADE_IN) || (state_d == ST_FADE_OUT);
  end

  assign status        = status_q;
  assign title_alpha   = alpha;
  assign prompt_on     = prompt_q;
  assign in_transition = in_tr_q;

endmodule
